lzc_word_tx: RTL and testbench
==============================

Name: lzc_word_tx

Overview:
- Transmit side of the leading-zero-counter word interface.
- Accepts one full operand of width*word bits from an upstream client and serialises it MSB-word-first onto the lzc data/Ivalid/mode inputs.
- Waits for the counter's Ovalid/zeros response and returns the count to the client as a single result pulse.
- Provides a watchdog timeout for a counter that never answers.

Parameters:
width, 8, bits per transmitted word (lzc data width)
word, 4, words per operand
TIMEOUT, 64, max cycles spent in WAIT before an error result is returned (≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  width*word  operand; bits [width*word-1 -: width] are sent first
in_mode  input  1  mode value forwarded unchanged to lzc for the whole transaction
in_valid  input  1  operand offered
in_ready  output  1  high only in IDLE; transfer when in_valid&&in_ready
data  output  width  word to lzc
Ivalid  output  1  data qualifier to lzc
mode  output  1  registered copy of in_mode
zeros  input  $clog2(width*word)+1  count from lzc
Ovalid  input  1  count qualifier from lzc
res_zeros  output  $clog2(width*word)+1  returned count
res_valid  output  1  one-cycle result pulse
res_err  output  1  qualifies res_valid: 1 = timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - state=IDLE; data=0, Ivalid=0, mode=0, res_zeros=0, res_valid=0, res_err=0, busy=0.
  - in_ready=1 on the first cycle after release.
- All outputs are registered; in_ready is decoded directly from state.
- FSM IDLE -> SEND -> WAIT -> DONE -> IDLE.
- IDLE:
  - On in_valid&&in_ready, capture in_data into a shift register and in_mode into mode.
  - Next state SEND; word index k=0.
- SEND:
  - Lasts exactly `word` consecutive cycles, Ivalid=1 on each.
  - Cycle k drives data = operand bits [width*(word-k)-1 -: width].
  - The first word appears the cycle after the acceptance edge, so acceptance-to-first-Ivalid latency is 1 cycle.
  - There are no gaps between words. After word-1, go to WAIT.
- WAIT:
  - Ivalid=0 and data=0; mode is held.
  - A cycle counter starts at 0 on entry.
- Ovalid sampling:
  - Ovalid is sampled in the final SEND cycle and in every WAIT cycle.
  - Ovalid during earlier SEND cycles is ignored.
- Response:
  - On the first sampled Ovalid=1, latch zeros into res_zeros and go to DONE.
  - res_valid=1 and res_err=0 are asserted in the next cycle (DONE).
- Timeout:
  - If the counter reaches TIMEOUT-1 with no Ovalid, go to DONE with res_err=1 and res_zeros=0.
  - If Ovalid arrives in that same final cycle, the valid count wins: res_err=0.
- DONE:
  - res_valid=1 for exactly one cycle, then IDLE.
  - in_ready rises the cycle after DONE, so transactions can be back-to-back with a 1-cycle gap.
  - res_zeros and res_err hold their values until the next DONE.
- Extra Ovalid pulses outside sampled windows, or after the first accepted one, are ignored.
- in_data and in_mode changes after acceptance have no effect.
- Reset mid-transaction (any state): Ivalid drops immediately (async), no res_valid is produced, and the partial operand is discarded.
- Transaction length: word cycles in SEND + WAIT duration + 1 cycle in DONE.

Test Plan:
- width=8, word=4, in_data=32'h0000_0001, mode=0.
  - Required: data 00,00,00,01 on 4 consecutive Ivalid cycles starting 1 cycle after acceptance.
  - Bench answers Ovalid with zeros=31 two cycles later → res_valid one cycle with res_zeros=31, res_err=0.
- in_data=32'hFFFF_FFFF, mode=1, Ovalid+zeros=0 on the last SEND cycle.
  - Required: mode=1 throughout the transaction.
  - Required: res_valid on the cycle after the 4th word with res_zeros=0.
- Ovalid never driven.
  - Required: exactly TIMEOUT=64 WAIT cycles, then res_valid=1, res_err=1, res_zeros=0.
  - Required: in_ready=1 on the following cycle.
- in_valid held high with two operands: 32'h00F0_0000, then 32'h0000_0100 (zeros 8, then 23).
  - Required: in_ready=0 while busy; second acceptance occurs the cycle after the first res_valid.
  - Required: results 8 then 23, in order.
- Stray Ovalid (zeros=5) during the 1st SEND cycle, real Ovalid (zeros=12) during WAIT.
  - Required: res_zeros=12.
- rst asserted during the 3rd SEND cycle.
  - Required: Ivalid=0 and busy=0 asynchronously; no res_valid.
  - Required: a fresh operand after release transmits all 4 words correctly.

Source files
------------

// File: rtl/lzc_word_tx_if.sv
// Client-side operand/result handshake plus the word link toward the leading-zero counter.
interface lzc_word_tx_if #(
    parameter int unsigned width = 8,
    parameter int unsigned word  = 4
);
    localparam int unsigned OPW = width * word;
    localparam int unsigned ZW  = $clog2(OPW) + 1;

    // client side
    logic [OPW-1:0] in_data;
    logic           in_mode;
    logic           in_valid;
    logic           in_ready;
    logic [ZW-1:0]  res_zeros;
    logic           res_valid;
    logic           res_err;
    logic           busy;

    // counter side
    logic [width-1:0] data;
    logic             Ivalid;
    logic             mode;
    logic [ZW-1:0]    zeros;
    logic             Ovalid;

    // transmitter view
    modport slave (
        input  in_data, in_mode, in_valid, zeros, Ovalid,
        output in_ready, res_zeros, res_valid, res_err, busy, data, Ivalid, mode
    );

    // client / counter-model view
    modport master (
        output in_data, in_mode, in_valid, zeros, Ovalid,
        input  in_ready, res_zeros, res_valid, res_err, busy, data, Ivalid, mode
    );
endinterface

// File: rtl/lzc_word_tx.sv
// Serialises one operand MSB-word-first to the leading-zero counter, waits for its
// count (with a watchdog) and hands the result back to the client as one pulse.
module lzc_word_tx #(
    parameter int unsigned width   = 8,
    parameter int unsigned word    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    lzc_word_tx_if.slave bus
);
    localparam int unsigned OPW = width * word;
    localparam int unsigned KW  = (word > 1) ? $clog2(word) : 1;
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(word - 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t         state;
    logic [OPW-1:0] shreg;   // remaining words, next one at the top
    logic [KW-1:0]  k;       // index of the word currently on the link
    logic [CW-1:0]  cnt;     // cycles spent in WAIT

    assign bus.in_ready = (state == IDLE);

    // Transaction FSM; every output toward client and counter is a register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            k             <= '0;
            cnt           <= '0;
            bus.data      <= '0;
            bus.Ivalid    <= 1'b0;
            bus.mode      <= 1'b0;
            bus.res_zeros <= '0;
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // first word goes out straight away; the rest wait in shreg
                        bus.data   <= bus.in_data[OPW-1 -: width];
                        bus.Ivalid <= 1'b1;
                        bus.mode   <= bus.in_mode;
                        bus.busy   <= 1'b1;
                        shreg      <= bus.in_data << width;
                        k          <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (k != K_LAST) begin
                        bus.data <= shreg[OPW-1 -: width];
                        shreg    <= shreg << width;
                        k        <= k + KW'(1);
                    end else begin
                        // last word on the link: the counter may already answer
                        bus.data   <= '0;
                        bus.Ivalid <= 1'b0;
                        cnt        <= '0;
                        if (bus.Ovalid) begin
                            bus.res_zeros <= bus.zeros;
                            bus.res_err   <= 1'b0;
                            bus.res_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // a real count takes priority over an expiring watchdog
                    if (bus.Ovalid) begin
                        bus.res_zeros <= bus.zeros;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end else if (cnt == C_LAST) begin
                        bus.res_zeros <= '0;
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    bus.res_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lzc_word_tx.sv
// Directed bench for lzc_word_tx: a timeline model predicts every output each cycle,
// and literal expectations pin the words, counts and latencies of each scenario.
module tb_lzc_word_tx;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORD  = 4;
    localparam int unsigned TMO   = 64;
    localparam int unsigned OPW   = WIDTH * WORD;
    localparam int unsigned ZW    = $clog2(OPW) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lzc_word_tx_if #(.width(WIDTH), .word(WORD)) bus ();

    lzc_word_tx #(.width(WIDTH), .word(WORD), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: outputs as a function of time since acceptance ----------------
    logic             m_idle, m_done;
    logic [OPW-1:0]   m_op;
    int               m_e;        // clock edges since the acceptance edge
    logic [WIDTH-1:0] exp_data;
    logic             exp_ivalid, exp_mode, exp_busy, exp_rv, exp_re;
    logic [ZW-1:0]    exp_rz;

    function automatic logic [WIDTH-1:0] word_of(input logic [OPW-1:0] op, input int i);
        logic [OPW-1:0] s;
        s = op >> (int'(WIDTH) * (int'(WORD) - 1 - i));
        return s[WIDTH-1:0];
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_done = 1'b0; m_e = 0; m_op = '0;
        exp_data = '0; exp_ivalid = 1'b0; exp_mode = 1'b0; exp_busy = 1'b0;
        exp_rv = 1'b0; exp_re = 1'b0; exp_rz = '0;
    endtask

    task automatic model_step();
        if (m_done) begin
            m_done = 1'b0; m_idle = 1'b1; exp_rv = 1'b0; exp_busy = 1'b0;
        end else if (m_idle) begin
            if (bus.in_valid === 1'b1) begin
                m_op = bus.in_data; exp_mode = bus.in_mode; m_e = 0; m_idle = 1'b0;
                exp_busy = 1'b1; exp_ivalid = 1'b1; exp_data = word_of(m_op, 0);
            end
        end else begin
            m_e++;
            if (m_e < int'(WORD)) begin
                exp_data = word_of(m_op, m_e);
            end else begin
                exp_ivalid = 1'b0; exp_data = '0;
                if (bus.Ovalid === 1'b1) begin
                    exp_rv = 1'b1; exp_rz = bus.zeros; exp_re = 1'b0; m_done = 1'b1;
                end else if (m_e == int'(WORD + TMO)) begin
                    exp_rv = 1'b1; exp_rz = '0; exp_re = 1'b1; m_done = 1'b1;
                end
            end
        end
    endtask

    // model advances on each rising edge from the inputs as they stood before it
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- compare process and observation logs ----------------
    int               cyc = 0;
    int               last_iv = 0;
    logic             prev_iv = 1'b0;
    logic [WIDTH-1:0] words_q[$];
    int               start_q[$];
    logic [ZW-1:0]    rz_q[$];
    logic             re_q[$];
    int               gap_q[$];
    int               rc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) model_reset();
            chk("in_ready",  32'(bus.in_ready),  32'(m_idle));
            chk("Ivalid",    32'(bus.Ivalid),    32'(exp_ivalid));
            chk("data",      32'(bus.data),      32'(exp_data));
            chk("mode",      32'(bus.mode),      32'(exp_mode));
            chk("busy",      32'(bus.busy),      32'(exp_busy));
            chk("res_valid", 32'(bus.res_valid), 32'(exp_rv));
            chk("res_zeros", 32'(bus.res_zeros), 32'(exp_rz));
            chk("res_err",   32'(bus.res_err),   32'(exp_re));
            if (bus.Ivalid === 1'b1) begin
                words_q.push_back(bus.data);
                if (!prev_iv) start_q.push_back(cyc);
                last_iv = cyc;
            end
            prev_iv = bus.Ivalid;
            if (bus.res_valid === 1'b1) begin
                rz_q.push_back(bus.res_zeros);
                re_q.push_back(bus.res_err);
                gap_q.push_back(cyc - last_iv);
                rc_q.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers (inputs change 1 time unit after the falling edge) ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // called in an IDLE cycle; returns during the first SEND cycle
    task automatic send_op(input logic [OPW-1:0] op, input logic md);
        bus.in_valid = 1'b1; bus.in_data = op; bus.in_mode = md;
        step();
        bus.in_valid = 1'b0; bus.in_data = OPW'($urandom); bus.in_mode = ~md;
    endtask

    task automatic pulse_ov(input int n, input logic [ZW-1:0] z);
        repeat (n) step();
        bus.Ovalid = 1'b1; bus.zeros = z;
        step();
        bus.Ovalid = 1'b0; bus.zeros = ZW'($urandom);
    endtask

    task automatic wait_results(input int target, input int budget);
        int i;
        i = 0;
        while (rz_q.size() < target && i < budget) begin
            step();
            i++;
        end
        chk("result_arrived", 32'(rz_q.size() >= target), 32'd1);
    endtask

    task automatic chk_words(input string name, input logic [31:0] op);
        chk({name, "_count"}, 32'(words_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < words_q.size(); i++)
            chk(name, 32'(words_q[i]), 32'(op[31 - 8*i -: 8]));
    endtask

    int tgt = 0;
    int nres;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0;
        bus.Ovalid = 1'b0; bus.zeros = '0;
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_Ivalid",   32'(bus.Ivalid),   32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: single low bit, answer two cycles after the last word, then a stray late pulse
        words_q.delete();
        send_op(32'h0000_0001, 1'b0);
        pulse_ov(5, ZW'(31));
        pulse_ov(0, ZW'(9));
        tgt++; wait_results(tgt, 20);
        chk_words("t1_word", 32'h0000_0001);
        chk("t1_zeros", 32'(rz_q[tgt-1]), 32'd31);
        chk("t1_err",   32'(re_q[tgt-1]), 32'd0);
        chk("t1_gap",   32'(gap_q[tgt-1]), 32'd3);
        step();

        // 2: all ones, mode=1, answer on the last SEND cycle
        send_op(32'hFFFF_FFFF, 1'b1);
        pulse_ov(3, ZW'(0));
        tgt++; wait_results(tgt, 20);
        chk("t2_zeros", 32'(rz_q[tgt-1]), 32'd0);
        chk("t2_err",   32'(re_q[tgt-1]), 32'd0);
        chk("t2_gap",   32'(gap_q[tgt-1]), 32'd1);
        step();

        // 3: counter never answers
        send_op(32'h1234_5678, 1'b0);
        tgt++; wait_results(tgt, 100);
        chk("t3_zeros", 32'(rz_q[tgt-1]), 32'd0);
        chk("t3_err",   32'(re_q[tgt-1]), 32'd1);
        chk("t3_gap",   32'(gap_q[tgt-1]), 32'(TMO + 1));
        step();
        chk("t3_in_ready_after", 32'(bus.in_ready), 32'd1);

        // 4: in_valid held high across two operands
        bus.in_valid = 1'b1; bus.in_data = 32'h00F0_0000; bus.in_mode = 1'b0;
        step();
        bus.in_data = 32'h0000_0100;
        pulse_ov(4, ZW'(8));
        tgt++; wait_results(tgt, 20);
        step();
        step();
        bus.in_valid = 1'b0;
        pulse_ov(3, ZW'(23));
        tgt++; wait_results(tgt, 20);
        chk("t4_first",  32'(rz_q[tgt-2]), 32'd8);
        chk("t4_second", 32'(rz_q[tgt-1]), 32'd23);
        chk("t4_back_to_back", 32'(start_q[start_q.size()-1] - rc_q[tgt-2]), 32'd2);
        step();

        // 5: stray count during the first word, real one during WAIT
        send_op(32'h0008_0000, 1'b1);
        pulse_ov(0, ZW'(5));
        pulse_ov(5, ZW'(12));
        tgt++; wait_results(tgt, 20);
        chk("t5_zeros", 32'(rz_q[tgt-1]), 32'd12);
        chk("t5_err",   32'(re_q[tgt-1]), 32'd0);
        step();

        // 6: reset during the third word, then a fresh operand
        send_op(32'hDEAD_BEEF, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t6_async_Ivalid", 32'(bus.Ivalid), 32'd0);
        chk("t6_async_busy",   32'(bus.busy),   32'd0);
        nres = rz_q.size();
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        chk("t6_no_result", 32'(rz_q.size()), 32'(nres));
        words_q.delete();
        send_op(32'hA5C3_0F96, 1'b0);
        pulse_ov(4, ZW'(0));
        tgt++; wait_results(tgt, 20);
        chk_words("t6_word", 32'hA5C3_0F96);
        chk("t6_zeros", 32'(rz_q[tgt-1]), 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
